// File: rtl/note_cmd_scheduler_pkg.sv
// Shared definitions for the note command scheduler.
// Contents: Avalon register addresses, CTRL/STATUS bit positions and the FSM state type.
package note_cmd_scheduler_pkg;

  // Register map (word addresses on avs_s0_address)
  localparam logic [1:0] AddrCmd    = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;

  // CTRL write bits
  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlFlushBit  = 1;
  localparam int unsigned CtrlClrOvfBit = 2;

  // STATUS read bits; [7:0] occupancy, [31:16] issued-command count
  localparam int unsigned StatEmptyBit = 8;
  localparam int unsigned StatFullBit  = 9;
  localparam int unsigned StatOvfBit   = 10;
  localparam int unsigned StatBusyBit  = 11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StHold
  } sched_state_e;

endpackage

// File: rtl/note_cmd_scheduler_if.sv
// Avalon-MM slave bus of the note command scheduler.
// Signals: avs_s0_address (2), avs_s0_write, avs_s0_read, avs_s0_writedata (32),
//          avs_s0_readdata (32, readLatency=1).
// Modports: master (HPS side / bench), slave (scheduler).
interface note_cmd_scheduler_if;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_write;
  logic        avs_s0_read;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;

  modport master (
    output avs_s0_address,
    output avs_s0_write,
    output avs_s0_read,
    output avs_s0_writedata,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_address,
    input  avs_s0_write,
    input  avs_s0_read,
    input  avs_s0_writedata,
    output avs_s0_readdata
  );
endinterface

// File: rtl/note_cmd_scheduler_fifo.sv
// Synchronous show-ahead FIFO for command words.
// Ports:
//   clk, n_rst      clock, synchronous active-low reset
//   flush           empties the FIFO; overrides push and pop in the same cycle
//   push, push_data write a word (caller only pushes when !full or popping)
//   pop             drop the head word (ignored when empty)
//   head            current head word, valid whenever !empty
//   count/full/empty occupancy flags
module note_cmd_scheduler_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (AddrW + 1)'(Depth));

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/note_cmd_scheduler.sv
// Avalon-MM command front-end: buffers note/one-shot words from the HPS and issues them to
// bank_manager_p one at a time as single-cycle pulses separated by a hold-off gap. Issue stalls
// while i_gen_clk_en is low so no command is lost or merged.
// Ports:
//   clk, n_rst     clock, synchronous active-low reset
//   avs            Avalon slave: addr 0 CMD push (W), 1 STATUS (R), 2 CTRL (W)
//   i_gen_clk_en   generator enable; 0 means the sample FIFO is full
//   o_cmd          issued command word, 0 when not valid
//   o_cmd_valid    one-cycle pulse qualifying o_cmd
//   o_overflow     sticky: a CMD push was dropped because the FIFO was full
module note_cmd_scheduler
  import note_cmd_scheduler_pkg::*;
#(
  parameter int unsigned CMD_W          = 16,
  parameter int unsigned CMD_DEPTH      = 8,
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  note_cmd_scheduler_if.slave    avs,
  input  logic                   i_gen_clk_en,
  output logic [CMD_W-1:0]       o_cmd,
  output logic                   o_cmd_valid,
  output logic                   o_overflow
);

  localparam int unsigned CntW = $clog2(CMD_DEPTH) + 1;
  // The decision cycle spent in IDLE counts as one of the hold-off cycles, so HOLD itself lasts
  // HOLDOFF_CYCLES-1 enabled cycles (at least one, since ISSUE always enters HOLD).
  localparam int unsigned HoldLast = (HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 2 : 0;
  localparam int unsigned HoldW    = (HoldLast > 0) ? $clog2(HoldLast + 1) : 1;

  sched_state_e     state_q;
  logic [HoldW-1:0] hold_q;
  logic [15:0]      issued_q;
  logic             enable_q;
  logic             overflow_q;
  logic [31:0]      readdata_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_valid_q;

  logic             cmd_wr, ctrl_wr, flush, push_req, push_ok, drop, pop;
  logic [CMD_W-1:0] fifo_head;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_full, fifo_empty;
  logic [31:0]      status;
  logic             unused_wdata;

  assign unused_wdata = ^avs.avs_s0_writedata[31:CMD_W];

  // Bus decode
  assign cmd_wr   = avs.avs_s0_write && (avs.avs_s0_address == AddrCmd);
  assign ctrl_wr  = avs.avs_s0_write && (avs.avs_s0_address == AddrCtrl);
  assign flush    = ctrl_wr && avs.avs_s0_writedata[CtrlFlushBit];
  assign push_req = cmd_wr && (avs.avs_s0_writedata[CMD_W-1:0] != '0);

  // A flush in IDLE also suppresses the pop so no word escapes a flush.
  assign pop     = (state_q == StIdle) && enable_q && !fifo_empty && i_gen_clk_en && !flush;
  assign push_ok = push_req && !flush && (!fifo_full || pop);
  assign drop    = push_req && !flush && fifo_full && !pop;

  note_cmd_scheduler_fifo #(
    .Width (CMD_W),
    .Depth (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .push      (push_ok),
    .push_data (avs.avs_s0_writedata[CMD_W-1:0]),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue FSM with registered command outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      issued_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q     <= StIssue;
            cmd_q       <= fifo_head;
            cmd_valid_q <= 1'b1;
            issued_q    <= issued_q + 16'd1;
          end
        end
        StIssue: begin
          state_q     <= StHold;
          hold_q      <= '0;
          cmd_q       <= '0;
          cmd_valid_q <= 1'b0;
        end
        StHold: begin
          // Counter freezes while the generator is stalled.
          if (i_gen_clk_en) begin
            if (hold_q == HoldW'(HoldLast)) begin
              state_q <= StIdle;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    status               = '0;
    status[7:0]          = 8'(fifo_count);
    status[StatEmptyBit] = fifo_empty;
    status[StatFullBit]  = fifo_full;
    status[StatOvfBit]   = overflow_q;
    status[StatBusyBit]  = (state_q != StIdle);
    status[31:16]        = issued_q;
  end

  // Control register, sticky overflow and registered read data
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      enable_q   <= 1'b1;
      overflow_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (ctrl_wr) enable_q <= avs.avs_s0_writedata[CtrlEnableBit];
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ctrl_wr && avs.avs_s0_writedata[CtrlClrOvfBit]) begin
        overflow_q <= 1'b0;
      end
      readdata_q <= (avs.avs_s0_read && (avs.avs_s0_address == AddrStatus)) ? status : '0;
    end
  end

  assign avs.avs_s0_readdata = readdata_q;
  assign o_cmd               = cmd_q;
  assign o_cmd_valid         = cmd_valid_q;
  assign o_overflow          = overflow_q;

endmodule

// File: tb/tb_note_cmd_scheduler.sv
// Bench for note_cmd_scheduler: directed scenarios followed by random bus traffic, every cycle
// compared against a queue-based reference model of the command scheduler.
module tb_note_cmd_scheduler;

  localparam int unsigned CmdW    = 16;
  localparam int unsigned Depth   = 8;
  localparam int          Holdoff = 4;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            gen_en = 1'b1;
  logic [CmdW-1:0] cmd;
  logic            cmd_valid;
  logic            overflow;

  note_cmd_scheduler_if bus ();

  note_cmd_scheduler #(
    .CMD_W          (CmdW),
    .CMD_DEPTH      (Depth),
    .HOLDOFF_CYCLES (Holdoff)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .avs          (bus),
    .i_gen_clk_en (gen_en),
    .o_cmd        (cmd),
    .o_cmd_valid  (cmd_valid),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending words, whether a pulse is showing, and how many enabled non-pulse
  // cycles remain before a new command may be taken (1 = may take one now).
  logic [CmdW-1:0] m_q[$];
  bit              m_pulse;
  int              m_gap;
  bit              m_en;
  bit              m_ovf;
  int unsigned     m_issued;
  logic [CmdW-1:0] m_cmd;
  logic [31:0]     m_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int pulse_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs being driven, then compare after the edge.
  task automatic step();
    logic [31:0] wd;
    logic [1:0]  a;
    bit          wr, rd, flush, push_req, pop, fits;
    wd = bus.avs_s0_writedata;
    a  = bus.avs_s0_address;
    wr = bus.avs_s0_write;
    rd = bus.avs_s0_read;
    if (!n_rst) begin
      m_q.delete();
      m_pulse  = 0;
      m_gap    = 1;
      m_en     = 1;
      m_ovf    = 0;
      m_issued = 0;
      m_cmd    = '0;
      m_rd     = '0;
    end else begin
      m_rd = '0;
      if (rd && a == 2'd1)
        m_rd = {m_issued[15:0], 4'h0, (m_pulse || m_gap > 1), m_ovf,
                (m_q.size() == Depth), (m_q.size() == 0), 8'(m_q.size())};
      flush    = wr && a == 2'd2 && wd[1];
      push_req = wr && a == 2'd0 && wd[CmdW-1:0] != '0;
      pop      = !m_pulse && m_gap == 1 && m_en && m_q.size() > 0 && gen_en && !flush;
      fits     = (m_q.size() < Depth) || pop;
      if (m_pulse) begin
        m_pulse = 0;
        m_gap   = Holdoff;
        m_cmd   = '0;
      end else if (gen_en && m_gap > 1) begin
        m_gap--;
      end
      if (pop) begin
        m_cmd   = m_q.pop_front();
        m_pulse = 1;
        m_issued++;
      end
      if (flush) m_q.delete();
      else if (push_req) begin
        if (fits) m_q.push_back(wd[CmdW-1:0]);
        else m_ovf = 1;
      end
      if (wr && a == 2'd2) begin
        m_en = wd[0];
        if (wd[2]) m_ovf = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("valid", 32'(cmd_valid), 32'(m_pulse));
    check("cmd", 32'(cmd), 32'(m_cmd));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("readdata", bus.avs_s0_readdata, m_rd);
    if (cmd_valid === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.avs_s0_write = 1'b0;
      bus.avs_s0_read  = 1'b0;
      step();
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_s0_address   = a;
    bus.avs_s0_writedata = d;
    bus.avs_s0_write     = 1'b1;
    bus.avs_s0_read      = 1'b0;
    step();
    bus.avs_s0_write     = 1'b0;
  endtask

  task automatic rd_status();
    bus.avs_s0_address = 2'd1;
    bus.avs_s0_read    = 1'b1;
    bus.avs_s0_write   = 1'b0;
    step();
    bus.avs_s0_read    = 1'b0;
  endtask

  initial begin
    int w;
    int base;
    bus.avs_s0_address   = '0;
    bus.avs_s0_write     = 1'b0;
    bus.avs_s0_read      = 1'b0;
    bus.avs_s0_writedata = '0;

    // Reset state
    n_rst = 1'b0;
    idle(2);
    n_rst = 1'b1;
    rd_status();
    check("reset_status", bus.avs_s0_readdata, 32'h0000_0100);

    // Single command: pulse 2 cycles after the write, count becomes 1
    pulse_cyc.delete();
    w = cyc;
    bus_wr(2'd0, 32'h0000_0145);
    idle(8);
    check("t1_npulse", 32'(pulse_cyc.size()), 32'd1);
    check("t1_latency", 32'(pulse_cyc[0] - w), 32'd2);
    rd_status();
    check("t1_count", 32'(bus.avs_s0_readdata[31:16]), 32'd1);

    // Burst of three: in order, 5 cycles apart
    pulse_cyc.delete();
    bus_wr(2'd0, 32'h0011);
    bus_wr(2'd0, 32'h0022);
    bus_wr(2'd0, 32'h0033);
    idle(20);
    check("t2_npulse", 32'(pulse_cyc.size()), 32'd3);
    check("t2_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd5);
    check("t2_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd5);

    // Disabled: 9 writes fill 8 entries and overflow
    bus_wr(2'd2, 32'h0);
    for (int i = 1; i <= 9; i++) bus_wr(2'd0, 32'(16'h0100 + i));
    rd_status();
    check("t3_full", 32'(bus.avs_s0_readdata[9]), 32'd1);
    check("t3_occ", 32'(bus.avs_s0_readdata[7:0]), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
    pulse_cyc.delete();
    bus_wr(2'd2, 32'h1);
    idle(60);
    check("t3_npulse", 32'(pulse_cyc.size()), 32'd8);
    bus_wr(2'd2, 32'h5);
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // Generator stall during HOLD freezes the hold-off
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd0, 32'h00a1);
    bus_wr(2'd0, 32'h00a2);
    bus_wr(2'd0, 32'h00a3);
    pulse_cyc.delete();
    bus_wr(2'd2, 32'h1);
    idle(3);
    gen_en = 1'b0;
    base = pulses;
    idle(20);
    check("t4_frozen", 32'(pulses - base), 32'd0);
    gen_en = 1'b1;
    idle(20);
    check("t4_npulse", 32'(pulse_cyc.size()), 32'd3);
    check("t4_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd25);
    check("t4_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd5);

    // Flush with 5 queued
    bus_wr(2'd2, 32'h0);
    for (int i = 1; i <= 5; i++) bus_wr(2'd0, 32'(16'h0200 + i));
    pulse_cyc.delete();
    bus_wr(2'd2, 32'h3);
    idle(30);
    rd_status();
    check("t5_occ", 32'(bus.avs_s0_readdata[7:0]), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_npulse", 32'(pulse_cyc.size()), 32'd0);

    // Reset during HOLD with 3 queued
    for (int i = 1; i <= 4; i++) bus_wr(2'd0, 32'(16'h0300 + i));
    n_rst = 1'b0;
    idle(1);
    n_rst = 1'b1;
    check("t6_valid", 32'(cmd_valid), 32'd0);
    check("t6_cmd", 32'(cmd), 32'd0);
    rd_status();
    check("t6_status", bus.avs_s0_readdata, 32'h0000_0100);
    pulse_cyc.delete();
    bus_wr(2'd0, 32'h0777);
    idle(5);
    check("t6_enabled", 32'(pulse_cyc.size()), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      gen_en = ($urandom_range(0, 9) != 0);
      bus.avs_s0_write = 1'b0;
      bus.avs_s0_read  = 1'b0;
      n_rst = 1'b1;
      if (r < 30) begin
        bus.avs_s0_address   = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'd0;
        bus.avs_s0_writedata = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hffff_0000) : $urandom;
        bus.avs_s0_write     = 1'b1;
      end else if (r < 40) begin
        bus.avs_s0_address = 2'($urandom_range(0, 3));
        bus.avs_s0_read    = 1'b1;
      end else if (r < 43) begin
        bus.avs_s0_address   = 2'd2;
        bus.avs_s0_writedata = {29'($urandom), ($urandom_range(0, 3) == 0),
                                ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) != 0)};
        bus.avs_s0_write     = 1'b1;
      end else if (r == 99 && $urandom_range(0, 3) == 0) begin
        n_rst = 1'b0;
      end
      step();
    end
    n_rst = 1'b1;
    gen_en = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
